// File: rtl/bcd2bin3_pkg.sv
// Shared definitions for the BCD<->binary converters: FSM encodings, digit/result widths, iteration count.
package bcd2bin3_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned ITER_N   = 10;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SR_W     = N_DIGITS * DIGIT_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for a nibble that is not a decimal digit.
  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 when the shifted digit is 8 or more.
module bcd_digit_adj
  import bcd2bin3_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] digit_adj_c
);

  always_comb begin
    digit_adj_c = digit;
    if (digit >= DIGIT_W'(8)) begin
      digit_adj_c = digit - DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd2bin3.sv
// Three-digit BCD to 10-bit binary converter, one reverse double-dabble step per cycle.
// Optional invalid-digit detection is enabled with `define BCD2BIN_CHECK_EN.
module bcd2bin3
  import bcd2bin3_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] centaines,
  input  logic [DIGIT_W-1:0] dizaines,
  input  logic [DIGIT_W-1:0] unites,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIN_W-1:0]   bin,
  output logic               err,
  output logic               busy
);

  state_t             state;
  state_t             state_nxt;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_shift_c;
  logic [SR_W-1:0]    sr_step_c;
  logic [DIGIT_W-1:0] hund_adj_c;
  logic [DIGIT_W-1:0] tens_adj_c;
  logic [DIGIT_W-1:0] unit_adj_c;
  logic [CNT_W-1:0]   cnt;
  logic               accept_c;
  logic               last_iter_c;
  logic               flag_c;

  assign accept_c    = in_valid & in_ready;
  assign last_iter_c = (cnt == CNT_W'(ITER_N - 1));

  // One step: shift the whole register right, then correct each digit field.
  assign sr_shift_c = sr >> 1;

  bcd_digit_adj u_adj_hund (
    .digit       (sr_shift_c[SR_W-1 -: DIGIT_W]),
    .digit_adj_c (hund_adj_c)
  );

  bcd_digit_adj u_adj_tens (
    .digit       (sr_shift_c[SR_W-DIGIT_W-1 -: DIGIT_W]),
    .digit_adj_c (tens_adj_c)
  );

  bcd_digit_adj u_adj_unit (
    .digit       (sr_shift_c[SR_W-2*DIGIT_W-1 -: DIGIT_W]),
    .digit_adj_c (unit_adj_c)
  );

  assign sr_step_c = {hund_adj_c, tens_adj_c, unit_adj_c, sr_shift_c[BIN_W-1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_c) state_nxt = CONV;
      CONV: if (last_iter_c) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Shift register, iteration counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      bin <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            sr  <= {centaines, dizaines, unites, BIN_W'(0)};
            cnt <= '0;
          end
        end
        CONV: begin
          sr  <= sr_step_c;
          cnt <= cnt + CNT_W'(1);
          if (last_iter_c) begin
            bin <= flag_c ? BIN_W'(0) : sr_step_c[BIN_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_q;

  // Invalid digits are remembered at accept and reported alongside the result only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept_c) begin
        bad_q <= digit_bad(centaines) | digit_bad(dizaines) | digit_bad(unites);
      end
      if (state == CONV && last_iter_c) begin
        err <= bad_q;
      end else if (state == DONE && out_ready) begin
        err <= 1'b0;
      end
    end
  end

  assign flag_c = bad_q;
`else
  assign err    = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
